// File: rtl/trace_pkg.sv
// trace_pkg: record, kind and state types shared by the trace monitor.
// Macro TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp to each record.
package trace_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        REG   = 3'd0,
        JMP   = 3'd1,
        BR_T  = 3'd2,
        BR_NT = 3'd3,
        STORE = 3'd4
    } trc_kind_e;

    typedef struct packed {
        trc_kind_e       kind;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0]     cycle;
`endif
    } trace_rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, HUNG} fsm_e;
endpackage

// File: rtl/core_trace_mon_if.sv
// core_trace_mon_if: trace record stream, valid/ready handshake.
// master drives the record and trc_valid; slave drives trc_ready.
interface core_trace_mon_if;
    import trace_pkg::*;

    logic            trc_valid;
    logic            trc_ready;
    trc_kind_e       trc_kind;
    logic [XLEN-1:0] trc_tag;
    logic [31:0]     trc_instr;
    logic [XLEN-1:0] trc_addr;
    logic [XLEN-1:0] trc_data;
    logic [31:0]     trc_cycle;

    modport master (
        output trc_valid, trc_kind, trc_tag, trc_instr,
        output trc_addr, trc_data, trc_cycle,
        input  trc_ready
    );

    modport slave (
        input  trc_valid, trc_kind, trc_tag, trc_instr,
        input  trc_addr, trc_data, trc_cycle,
        output trc_ready
    );
endinterface

// File: rtl/trace_fifo_mpush.sv
// trace_fifo_mpush: NUM_CH-push / 1-pop FIFO of trace_rec_t.
// Ports: push_en/push_rec per channel, pop_ready, head_valid/head_rec, free slot count.
module trace_fifo_mpush
    import trace_pkg::*;
#(
    parameter  int NUM_CH = 3,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       push_en,
    input  trace_rec_t [NUM_CH-1:0] push_rec,
    input  logic                    pop_ready,
    output logic                    head_valid,
    output trace_rec_t              head_rec,
    output logic [PW-1:0]           free
);
    trace_rec_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] n_push;
    logic [AW-1:0] widx [NUM_CH];
    logic          pop;

    // Extra pointer MSB separates full from empty; the
    // difference is the occupancy in both cases.
    assign head_valid = (wr_ptr != rd_ptr);
    assign pop        = head_valid & pop_ready;
    assign head_rec   = mem[rd_ptr[AW-1:0]];
    assign free       = PW'(DEPTH) - (wr_ptr - rd_ptr);

    // Enabled channels land in consecutive slots, lowest index first.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            widx[i] = wr_ptr[AW-1:0] + n_push[AW-1:0];
            n_push  = n_push + PW'(push_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_en[i]) mem[widx[i]] <= push_rec[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push;
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end
endmodule

// File: rtl/core_trace_mon.sv
// core_trace_mon: retirement trace monitor with finish-store detector and watchdog.
// Ports: ch_* retirement channels in, trc stream out (master), finish, wdog_expired, drop_cnt.
// Macro TRACE_CYCLE_STAMP_EN stamps each record with a free-running cycle count.
module core_trace_mon
    import trace_pkg::*;
#(
    parameter int              NUM_CH      = 3,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              WDOG_LIMIT  = 1000,
    parameter logic [XLEN-1:0] FINISH_ADDR = 32'h1000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH*3-1:0]    ch_kind,
    input  logic [NUM_CH*XLEN-1:0] ch_tag,
    input  logic [NUM_CH*32-1:0]   ch_instr,
    input  logic [NUM_CH*XLEN-1:0] ch_addr,
    input  logic [NUM_CH*XLEN-1:0] ch_data,
    core_trace_mon_if.master       trc,
    output logic                   finish,
    output logic                   wdog_expired,
    output logic [15:0]            drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    fsm_e                    state;
    logic [WW-1:0]           wdog_cnt;
    logic [PW-1:0]           free;
    logic [PW-1:0]           rank;
    logic [PW-1:0]           n_drop;
    logic [NUM_CH-1:0]       push_en;
    logic                    cut;
    logic                    head_valid;
    trace_rec_t              head;
    trace_rec_t [NUM_CH-1:0] recs;
    logic [16:0]             drop_sum;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    assign trc.trc_cycle = head.cycle;
`else
    assign trc.trc_cycle = 32'h0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            recs[i].kind  = trc_kind_e'(ch_kind[i*3 +: 3]);
            recs[i].tag   = ch_tag[i*XLEN +: XLEN];
            recs[i].instr = ch_instr[i*32 +: 32];
            recs[i].addr  = ch_addr[i*XLEN +: XLEN];
            recs[i].data  = ch_data[i*XLEN +: XLEN];
`ifdef TRACE_CYCLE_STAMP_EN
            recs[i].cycle = cyc;
`endif
        end
    end

    // Valid channels take free slots in index order. A pushed
    // finish store cuts off every younger channel without a drop.
    always_comb begin
        push_en = '0;
        rank    = '0;
        n_drop  = '0;
        cut     = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !cut) begin
                    if (rank < free) begin
                        push_en[i] = 1'b1;
                        rank       = rank + PW'(1);
                        if (recs[i].kind == STORE &&
                            recs[i].addr == FINISH_ADDR)
                            cut = 1'b1;
                    end else begin
                        n_drop = n_drop + PW'(1);
                    end
                end
            end
        end
    end

    trace_fifo_mpush #(
        .NUM_CH (NUM_CH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (push_en),
        .push_rec   (recs),
        .pop_ready  (trc.trc_ready),
        .head_valid (head_valid),
        .head_rec   (head),
        .free       (free)
    );

    assign trc.trc_valid = head_valid;
    assign trc.trc_kind  = head.kind;
    assign trc.trc_tag   = head.tag;
    assign trc.trc_instr = head.instr;
    assign trc.trc_addr  = head.addr;
    assign trc.trc_data  = head.data;

    assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wdog_cnt     <= '0;
            finish       <= 1'b0;
            wdog_expired <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                    if (|ch_valid) begin
                        wdog_cnt <= '0;
                    end else if (wdog_cnt == WW'(WDOG_LIMIT - 1)) begin
                        state        <= HUNG;
                        wdog_expired <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                    end
                    if (cut) state <= DRAIN;
                end
                DRAIN: begin
                    if (!head_valid) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE, HUNG: ;
            endcase
        end
    end
endmodule
